// File: rtl/dmem_pipe.sv
// dmem_pipe: multi-cycle word data memory with valid/ready request and a
// one-cycle response pulse after a fixed DELAY.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_valid / req_ready  request handshake (accept on valid && ready)
//   mem_read / mem_write   load / store select; both = store + old data
//   addr, din              byte address (word index wraps), store data
//   resp_valid             one-cycle completion pulse
//   dout, resp_err         registered load data and misalignment flag
//
// Optional macro: DMEM_ALIGN_CHECK_EN (misaligned requests flag resp_err,
// return dout=0 and never write memory).
module dmem_pipe #(
    parameter int MEM_DEPTH = 16384,
    parameter int DELAY     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic        resp_valid,
    output logic [31:0] dout,
    output logic        resp_err
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic [31:0]   din_q;
    logic          rd_q, wr_q;
    logic [31:0]   dout_q, dout_d;
    logic          err_q, err_d;
    logic          accept;
    logic          done;
    logic          bad;
    logic          do_wr;

    logic [31:0]   mem_q [MEM_DEPTH];

    // Upper address bits wrap away; low bits only matter with alignment
    // checking.
    logic          unused_addr;
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    logic mis_q;
    assign bad = mis_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else if (accept) begin
            mis_q <= |addr[1:0];
        end
    end
`else
    assign bad = 1'b0;
`endif

    // Ready is a pure state decode: RESP can accept the next request.
    assign req_ready  = (state_q != BUSY);
    assign resp_valid = (state_q == RESP);
    assign dout       = dout_q;
    assign resp_err   = err_q;
    assign accept     = req_valid && req_ready;
    assign do_wr      = done && wr_q && !bad;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        err_d   = err_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = 4'(DELAY - 1);
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    done    = 1'b1;
                    err_d   = bad;
                    // Read is taken before this edge's write lands,
                    // so read+write returns the old word.
                    dout_d  = (rd_q && !bad) ? mem_q[idx_q] : 32'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (accept) begin
                    state_d = BUSY;
                    cnt_d   = 4'(DELAY - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            dout_q  <= 32'd0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            din_q   <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            if (accept) begin
                idx_q <= addr[AW+1:2];
                din_q <= din;
                rd_q  <= mem_read;
                wr_q  <= mem_write;
            end
        end
    end

    // Memory is not cleared; a reset on the completion edge drops the write.
    always_ff @(posedge clk) begin
        if (do_wr && !reset) begin
            mem_q[idx_q] <= din_q;
        end
    end

endmodule
